// File: rtl/mvu_job_pkg.sv
// Shared types for the MVU job dispatcher: job descriptor layout and FSM states.
package mvu_job_pkg;

  typedef struct packed {
    logic [2:0]  mvu_id;
    logic [3:0]  wprec;
    logic [3:0]  iprec;
    logic [3:0]  oprec;
    logic [5:0]  quant_msb;
    logic [14:0] countdown;
    logic [15:0] wbaseaddr;
    logic [15:0] ibaseaddr;
    logic [15:0] obaseaddr;
  } job_t;

  localparam int unsigned JOB_W = 84;
  // Config payload is the descriptor without its routing field (mvu_id sits in the MSBs).
  localparam int unsigned CFG_W = JOB_W - 3;

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    START
  } dispatch_state_t;

  // Strip the routing field off a descriptor.
  function automatic logic [CFG_W-1:0] job_cfg(input job_t job);
    return job[CFG_W-1:0];
  endfunction

endpackage

// File: rtl/mvu_job_dispatcher_if.sv
// Job stream plus MVU configuration/start/irq bus between a job source and the dispatcher.
interface mvu_job_dispatcher_if #(
  parameter int unsigned N = 8
) ();
  import mvu_job_pkg::*;

  logic             job_valid;
  logic             job_ready;
  job_t             job_desc;
  logic [CFG_W-1:0] mvu_cfg_data;
  logic [N-1:0]     mvu_cfg_we;
  logic [N-1:0]     mvu_start;
  logic [N-1:0]     mvu_irq;

  // Job source / MVU-array side.
  modport master (
    output job_valid,
    output job_desc,
    output mvu_irq,
    input  job_ready,
    input  mvu_cfg_data,
    input  mvu_cfg_we,
    input  mvu_start
  );

  // Dispatcher side.
  modport slave (
    input  job_valid,
    input  job_desc,
    input  mvu_irq,
    output job_ready,
    output mvu_cfg_data,
    output mvu_cfg_we,
    output mvu_start
  );

endinterface

// File: rtl/mvu_job_fifo.sv
// In-order synchronous FIFO with a registered full flag (power-of-two depth).
module mvu_job_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_o;

  // Occupancy and next full flag.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
    full_d = (count_d == CntW'(Depth));
  end

  // Pointers and flags; full reads as set during reset so nothing is accepted then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage, no reset needed: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// Buffers job descriptors, programs and starts MVUs in order, tracks busy/irq/watchdog state.
module mvu_job_dispatcher
  import mvu_job_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mvu_job_dispatcher_if.slave   bus,
  output logic [N-1:0]          busy,
  output logic [31:0]           jobs_issued,
  output logic [31:0]           jobs_done,
  output logic [N-1:0]          err_spurious,
  output logic [N-1:0]          err_timeout,
  output logic                  idle
);

  localparam bit          WdogEn  = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WdogMax = WdogEn ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned WdogW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  job_t             head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             head_id_ok;
  logic [N-1:0]     head_onehot;

  dispatch_state_t  state_q, state_d;
  logic [N-1:0]     cfg_we, start;
  logic [CFG_W-1:0] cfg_data;

  logic [N-1:0]     busy_q, busy_d;
  logic [N-1:0]     spur_q, spur_d;
  logic [N-1:0]     tout_q, tout_d;
  logic [N-1:0]     accept, expire;
  logic [31:0]      issued_q, issued_d;
  logic [31:0]      done_q, done_d;
  logic [WdogW-1:0] wdog_q [N];
  logic [WdogW-1:0] wdog_d [N];

  mvu_job_fifo #(
    .Width (JOB_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (bus.job_valid),
    .wdata_i (bus.job_desc),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_id_ok  = (32'(head.mvu_id) < N);
  // An out-of-range id shifts out to zero, so such a head can never strobe anything.
  assign head_onehot = N'(1) << head.mvu_id;

  // Dispatch FSM: IDLE waits for an unblocked head, CFG programs, START fires and pops.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    cfg_we   = '0;
    start    = '0;
    cfg_data = '0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (!head_id_ok) begin
            fifo_pop = 1'b1;
          end else if ((busy_q & head_onehot) == '0) begin
            state_d = CFG;
          end
        end
      end
      CFG: begin
        cfg_we   = head_onehot;
        cfg_data = job_cfg(head);
        state_d  = START;
      end
      START: begin
        start    = head_onehot;
        fifo_pop = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-MVU busy, irq classification and watchdog next state.
  always_comb begin
    accept = '0;
    expire = '0;
    busy_d = busy_q;
    spur_d = spur_q;
    tout_d = tout_q;
    for (int i = 0; i < N; i++) begin
      wdog_d[i] = '0;
      accept[i] = bus.mvu_irq[i] && busy_q[i];
      // An irq in the expiry cycle wins over the watchdog.
      expire[i] = WdogEn && busy_q[i] && !bus.mvu_irq[i] && (wdog_q[i] == WdogW'(WdogMax));
      if (bus.mvu_irq[i] && !busy_q[i]) spur_d[i] = 1'b1;
      if (expire[i]) tout_d[i] = 1'b1;
      busy_d[i] = (busy_q[i] && !accept[i] && !expire[i]) || start[i];
      if (WdogEn && busy_q[i] && busy_d[i]) wdog_d[i] = wdog_q[i] + WdogW'(1);
    end
    issued_d = issued_q + 32'(state_q == START && head_id_ok);
    done_d   = done_q + 32'($countones(accept));
  end

  // State, tracking and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= '0;
      spur_q   <= '0;
      tout_q   <= '0;
      issued_q <= '0;
      done_q   <= '0;
      wdog_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      spur_q   <= spur_d;
      tout_q   <= tout_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.job_ready    = !fifo_full;
  assign bus.mvu_cfg_we   = cfg_we;
  assign bus.mvu_cfg_data = cfg_data;
  assign bus.mvu_start    = start;

  assign busy         = busy_q;
  assign jobs_issued  = issued_q;
  assign jobs_done    = done_q;
  assign err_spurious = spur_q;
  assign err_timeout  = tout_q;
  assign idle         = fifo_empty && (state_q == IDLE) && (busy_q == '0);

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Directed bench: table of single-job vectors plus hand-written multi-cycle sequences.
module tb_mvu_job_dispatcher;
  import mvu_job_pkg::*;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mvu_job_dispatcher_if #(.N(N)) bus ();
  mvu_job_dispatcher_if #(.N(N)) bus_wd ();

  logic [N-1:0] busy, err_spurious, err_timeout;
  logic [31:0]  jobs_issued, jobs_done;
  logic         idle;
  logic [N-1:0] busy_wd, err_spurious_wd, err_timeout_wd;
  logic [31:0]  jobs_issued_wd, jobs_done_wd;
  logic         idle_wd;

  mvu_job_dispatcher #(.N(N), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .jobs_issued  (jobs_issued),
    .jobs_done    (jobs_done),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout),
    .idle         (idle)
  );

  mvu_job_dispatcher #(.N(N), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut_wd (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_wd),
    .busy         (busy_wd),
    .jobs_issued  (jobs_issued_wd),
    .jobs_done    (jobs_done_wd),
    .err_spurious (err_spurious_wd),
    .err_timeout  (err_timeout_wd),
    .idle         (idle_wd)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    job_t             desc;
    logic [N-1:0]     exp_oh;
    logic [CFG_W-1:0] exp_cfg;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic job_t mk(input logic [2:0] id, input logic [3:0] w, input logic [3:0] i,
                              input logic [3:0] o, input logic [5:0] q, input logic [14:0] cnt,
                              input logic [15:0] wb, input logic [15:0] ib, input logic [15:0] ob);
    job_t j;
    j.mvu_id = id; j.wprec = w; j.iprec = i; j.oprec = o; j.quant_msb = q;
    j.countdown = cnt; j.wbaseaddr = wb; j.ibaseaddr = ib; j.obaseaddr = ob;
    return j;
  endfunction

  // Returns in the cycle after the handshake edge.
  task automatic push(input bit wd, input job_t d);
    int n = 0;
    if (wd) begin bus_wd.job_valid = 1'b1; bus_wd.job_desc = d; end
    else    begin bus.job_valid = 1'b1;    bus.job_desc = d;    end
    while (!(wd ? bus_wd.job_ready : bus.job_ready) && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", n < 50, 1'b1);
    tick();
    if (wd) bus_wd.job_valid = 1'b0;
    else    bus.job_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input logic [N-1:0] exp, input int budget);
    int n = 0;
    while (bus.mvu_start == '0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.mvu_start, exp);
    tick();
  endtask

  int unsigned exp_issued = 0;
  int unsigned exp_done = 0;

  initial begin
    job_t             bp [6];
    logic [CFG_W-1:0] bp_cfg [6];
    int acc, ncfg, nstart, ncomp, n;
    bit take;

    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_desc = '0; bus.mvu_irq = '0;
    bus_wd.job_valid = 1'b0; bus_wd.job_desc = '0; bus_wd.mvu_irq = '0;

    vecs[0].desc = mk(3'd3, 4'd2, 4'd3, 4'd4, 6'd9, 15'd100, 16'h1000, 16'h2000, 16'h3000);
    vecs[0].exp_oh = 8'h08;
    vecs[0].exp_cfg = {4'd2, 4'd3, 4'd4, 6'd9, 15'd100, 16'h1000, 16'h2000, 16'h3000};
    vecs[1].desc = mk(3'd0, 4'hF, 4'h1, 4'h8, 6'h3F, 15'h7FFF, 16'hFFFF, 16'h0001, 16'h8000);
    vecs[1].exp_oh = 8'h01;
    vecs[1].exp_cfg = {4'hF, 4'h1, 4'h8, 6'h3F, 15'h7FFF, 16'hFFFF, 16'h0001, 16'h8000};
    vecs[2].desc = mk(3'd7, 4'd8, 4'd8, 4'd1, 6'd0, 15'd1, 16'hA5A5, 16'h5A5A, 16'h0F0F);
    vecs[2].exp_oh = 8'h80;
    vecs[2].exp_cfg = {4'd8, 4'd8, 4'd1, 6'd0, 15'd1, 16'hA5A5, 16'h5A5A, 16'h0F0F};
    vecs[3].desc = mk(3'd5, 4'd1, 4'd2, 4'd3, 6'd21, 15'd4660, 16'h1234, 16'h5678, 16'h9ABC);
    vecs[3].exp_oh = 8'h20;
    vecs[3].exp_cfg = {4'd1, 4'd2, 4'd3, 6'd21, 15'd4660, 16'h1234, 16'h5678, 16'h9ABC};

    // Reset values.
    repeat (3) tick();
    chk("rst_job_ready", bus.job_ready, 1'b0);
    chk("rst_cfg_we", bus.mvu_cfg_we, '0);
    chk("rst_cfg_data", bus.mvu_cfg_data, '0);
    chk("rst_start", bus.mvu_start, '0);
    chk("rst_busy", busy, '0);
    chk("rst_issued", jobs_issued, 0);
    chk("rst_done", jobs_done, 0);
    chk("rst_errs", {err_spurious, err_timeout}, '0);
    chk("rst_idle", idle, 1'b1);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus.job_ready, 1'b1);

    // Single-job latency and payload, one vector per MVU id.
    for (int v = 0; v < 4; v++) begin
      push(1'b0, vecs[v].desc);
      chk("vec_we_t1", bus.mvu_cfg_we, '0);
      tick();
      chk("vec_we_t2", bus.mvu_cfg_we, vecs[v].exp_oh);
      chk("vec_cfg_data", bus.mvu_cfg_data, vecs[v].exp_cfg);
      chk("vec_start_t2", bus.mvu_start, '0);
      tick();
      chk("vec_start_t3", bus.mvu_start, vecs[v].exp_oh);
      chk("vec_we_t3", bus.mvu_cfg_we, '0);
      tick();
      exp_issued++;
      chk("vec_busy_t4", busy, vecs[v].exp_oh);
      chk("vec_issued", jobs_issued, exp_issued);
      chk("vec_idle_busy", idle, 1'b0);
      repeat (6) tick();
      bus.mvu_irq = vecs[v].exp_oh;
      tick();
      bus.mvu_irq = '0;
      exp_done++;
      chk("vec_busy_cleared", busy, '0);
      chk("vec_done", jobs_done, exp_done);
      chk("vec_idle_after", idle, 1'b1);
    end

    // Reset while the first of two queued jobs is in CFG.
    push(1'b0, mk(3'd0, 4'd1, 4'd1, 4'd1, 6'd1, 15'd1, 16'd1, 16'd1, 16'd1));
    push(1'b0, mk(3'd1, 4'd2, 4'd2, 4'd2, 6'd2, 15'd2, 16'd2, 16'd2, 16'd2));
    chk("midrst_in_cfg", bus.mvu_cfg_we, 8'h01);
    rst = 1'b1;
    tick();
    chk("midrst_we", bus.mvu_cfg_we, '0);
    chk("midrst_start", bus.mvu_start, '0);
    chk("midrst_ready", bus.job_ready, 1'b0);
    chk("midrst_issued", jobs_issued, 0);
    rst = 1'b0;
    exp_issued = 0;
    exp_done = 0;
    tick();
    chk("midrst_idle", idle, 1'b1);
    repeat (5) tick();
    chk("midrst_no_issue", jobs_issued, 0);
    chk("midrst_no_busy", busy, '0);

    // Head-of-line blocking: 1, 1, 2.
    push(1'b0, mk(3'd1, 4'd1, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0011));
    push(1'b0, mk(3'd1, 4'd2, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0012));
    push(1'b0, mk(3'd2, 4'd3, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0021));
    wait_start("hol_first", 8'h02, 20);
    repeat (10) tick();
    chk("hol_blocked_busy", busy, 8'h02);
    chk("hol_blocked_issued", jobs_issued, 1);
    bus.mvu_irq = 8'h02;
    tick();
    bus.mvu_irq = '0;
    wait_start("hol_second", 8'h02, 20);
    wait_start("hol_third", 8'h04, 20);
    chk("hol_busy", busy, 8'h06);
    chk("hol_issued", jobs_issued, 3);
    bus.mvu_irq = 8'h06;
    tick();
    bus.mvu_irq = '0;
    chk("hol_done", jobs_done, 3);
    chk("hol_busy_clear", busy, '0);
    exp_issued = 3;
    exp_done = 3;

    // Backpressure: six jobs to MVU 0, irqs held off for the first 25 cycles.
    for (int k = 0; k < 6; k++) begin
      bp[k] = mk(3'd0, 4'(k), 4'd7, 4'd6, 6'(k), 15'(k), 16'hBEEF, 16'hCAFE, 16'(16'h0100 + k));
      bp_cfg[k] = {4'(k), 4'd7, 4'd6, 6'(k), 15'(k), 16'hBEEF, 16'hCAFE, 16'(16'h0100 + k)};
    end
    acc = 0; ncfg = 0; nstart = 0; ncomp = 0;
    bus.job_valid = 1'b1;
    bus.job_desc = bp[0];
    for (int c = 0; c < 300 && ncomp < 6; c++) begin
      if (bus.mvu_cfg_we == 8'h01 && ncfg < 6) begin
        chk("bp_cfg_order", bus.mvu_cfg_data, bp_cfg[ncfg]);
        ncfg++;
      end
      if (bus.mvu_start == 8'h01) nstart++;
      if (c == 24) begin
        chk("bp_accepts", acc, 5);
        chk("bp_ready_low", bus.job_ready, 1'b0);
        chk("bp_busy", busy, 8'h01);
        chk("bp_issued_1", jobs_issued, exp_issued + 1);
      end
      take = bus.job_valid && bus.job_ready;
      if (c >= 25 && busy[0]) begin
        bus.mvu_irq = 8'h01;
        ncomp++;
      end else begin
        bus.mvu_irq = '0;
      end
      tick();
      if (take) begin
        acc++;
        if (acc < 6) bus.job_desc = bp[acc];
        else bus.job_valid = 1'b0;
      end
    end
    bus.mvu_irq = '0;
    exp_issued += 6;
    exp_done += 6;
    chk("bp_all_accepted", acc, 6);
    chk("bp_cfg_count", ncfg, 6);
    chk("bp_start_count", nstart, 6);
    chk("bp_issued", jobs_issued, exp_issued);
    chk("bp_done", jobs_done, exp_done);
    chk("bp_idle", idle, 1'b1);

    // Simultaneous irqs on MVUs 0, 4, 7, then a spurious irq on idle MVU 5.
    push(1'b0, mk(3'd0, 4'd0, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0));
    push(1'b0, mk(3'd4, 4'd0, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0));
    push(1'b0, mk(3'd7, 4'd0, 4'd0, 4'd0, 6'd0, 15'd0, 16'h0, 16'h0, 16'h0));
    n = 0;
    while (busy != 8'h91 && n < 30) begin
      tick();
      n++;
    end
    chk("sim_busy", busy, 8'h91);
    bus.mvu_irq = 8'h91;
    tick();
    bus.mvu_irq = '0;
    exp_done += 3;
    chk("sim_busy_clear", busy, '0);
    chk("sim_done", jobs_done, exp_done);
    chk("sim_no_spurious", err_spurious, '0);
    bus.mvu_irq = 8'h20;
    tick();
    bus.mvu_irq = '0;
    chk("spur_set", err_spurious, 8'h20);
    repeat (5) tick();
    chk("spur_sticky", err_spurious, 8'h20);
    chk("spur_done_same", jobs_done, exp_done);
    chk("spur_busy", busy, '0);
    chk("no_timeout_disabled", err_timeout, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("spur_cleared", err_spurious, '0);
    chk("rst2_done", jobs_done, 0);
    chk("rst2_issued", jobs_issued, 0);

    // Watchdog: irq on the 16th busy cycle completes normally.
    push(1'b1, mk(3'd2, 4'd1, 4'd1, 4'd1, 6'd1, 15'd1, 16'h1, 16'h1, 16'h1));
    repeat (3) tick();
    chk("wd_a_busy", busy_wd, 8'h04);
    repeat (15) tick();
    chk("wd_a_busy_16th", busy_wd, 8'h04);
    bus_wd.mvu_irq = 8'h04;
    tick();
    bus_wd.mvu_irq = '0;
    chk("wd_a_clear", busy_wd, '0);
    chk("wd_a_done", jobs_done_wd, 1);
    chk("wd_a_no_timeout", err_timeout_wd, '0);
    chk("wd_a_no_spurious", err_spurious_wd, '0);

    // Watchdog: no irq, busy drops after exactly 16 cycles.
    push(1'b1, mk(3'd2, 4'd2, 4'd2, 4'd2, 6'd2, 15'd2, 16'h2, 16'h2, 16'h2));
    repeat (3) tick();
    chk("wd_b_busy", busy_wd, 8'h04);
    n = 0;
    while (busy_wd[2] && n < 40) begin
      tick();
      n++;
    end
    chk("wd_b_busy_cycles", n, 16);
    chk("wd_b_timeout", err_timeout_wd, 8'h04);
    chk("wd_b_done_same", jobs_done_wd, 1);
    chk("wd_b_issued", jobs_issued_wd, 2);
    chk("wd_b_idle", idle_wd, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvu_job_dispatcher.md
Name: mvu_job_dispatcher

Overview:
Front-end stage directly upstream of mvutop. It accepts packed job descriptors on a valid/ready stream and buffers them in a small in-order FIFO. For each job it programs the target MVU's configuration bus, fires a start pulse, and tracks per-MVU busy state until that MVU's irq returns. It also reports issue/completion counts, spurious-irq errors and watchdog timeouts, for the testers and for a future host controller.

Parameters:
N, 8, number of MVUs driven (must match mvutop)
FIFO_DEPTH, 4, job FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 0, per-MVU watchdog limit in busy cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  descriptor valid
job_ready  out  1  FIFO can accept (registered: not full and not in reset)
job_desc  in  JOB_W  packed job_t
mvu_cfg_data  out  CFG_W  job_t minus mvu_id, held stable during the CFG cycle
mvu_cfg_we  out  N  one-hot config write strobe
mvu_start  out  N  one-hot start pulse, one cycle
mvu_irq  in  N  per-MVU completion pulse, one cycle
busy  out  N  per-MVU job outstanding
jobs_issued  out  32  start pulses issued, wraps at 2^32
jobs_done  out  32  irqs accepted as completions, wraps at 2^32
err_spurious  out  N  sticky: irq seen while not busy
err_timeout  out  N  sticky: watchdog fired
idle  out  1  FIFO empty, FSM in IDLE, and busy == 0

Behaviour:
- Reset values: all outputs 0, except idle = 1. Reset flushes the FIFO, forces the FSM to IDLE and clears busy, the counters, the sticky errors and the watchdogs. Reset mid-job is legal and loses in-flight jobs silently.
- Input stream: a transfer occurs when job_valid && job_ready at a rising edge. The descriptor must be held while valid && !ready. Data written to a full FIFO is never accepted.
- FSM states:
  - IDLE: if the FIFO is non-empty and busy[head.mvu_id] == 0, go to CFG. Otherwise stay; in-order head-of-line blocking applies, and there is no reordering.
  - CFG: mvu_cfg_we[id] = 1 and mvu_cfg_data = head fields for exactly one cycle. Go to START.
  - START: mvu_start[id] = 1 for one cycle, pop the FIFO, jobs_issued += 1, busy[id] set at the closing edge. Return to IDLE.
- Latency: handshake in cycle t -> cfg_we in cycle t+2 -> start in cycle t+3 -> busy[id] high from t+4. Peak throughput is one job per 3 cycles.
- head.mvu_id >= N: the job is dropped at IDLE (pop only, no strobes) and the matching jobs_issued increment does not occur.
- irq handling, per MVU i, each cycle:
  - mvu_irq[i] && busy[i]: clear busy[i] at the edge, count a completion.
  - mvu_irq[i] && !busy[i] (this includes the START cycle of that MVU): set err_spurious[i]; busy is unchanged.
  - jobs_done adds the popcount of accepted completions, so multiple irqs in the same cycle are all counted.
- Watchdog (TIMEOUT_CYCLES > 0):
  - wdog[i] counts cycles with busy[i] high and is cleared when busy[i] is low.
  - When wdog[i] == TIMEOUT_CYCLES-1 and no irq: clear busy[i], set err_timeout[i], jobs_done unchanged.
  - An irq in the same cycle wins and is treated as a normal completion.
- A busy[i] clear and a new CFG for the same i never overlap, because the FSM samples busy in IDLE.

Decomposition:
- mvu_job_pkg (shared): job_t packed struct {mvu_id[2:0], wprec[3:0], iprec[3:0], oprec[3:0], quant_msb[5:0], countdown[14:0], wbaseaddr[15:0], ibaseaddr[15:0], obaseaddr[15:0]}; JOB_W = 84; CFG_W = 81; enum dispatch_state_t {IDLE, CFG, START}.
- One sub-module: mvu_job_fifo (parameterised synchronous FIFO: push/pop/full/empty, registered full flag). FSM, busy tracking, counters and watchdogs stay in the top.

Test Plan:
- Reset mid-stream: push 2 jobs, assert rst during CFG -> all strobes 0 next cycle, job_ready 0 during reset, idle = 1 after, jobs_issued = 0.
- Single job to mvu_id 3: handshake at t -> mvu_cfg_we = 8'h08 at t+2 with matching cfg_data, mvu_start = 8'h08 at t+3, busy = 8'h08 from t+4. irq[3] at t+10 -> busy = 0 at t+11, jobs_done = 1.
- Head-of-line blocking: jobs to MVU 1, 1, 2 back to back -> second job waits for irq[1]; MVU 2 starts only after the second MVU 1 start; jobs_issued = 3.
- Backpressure: 6 jobs to MVU 0 with FIFO_DEPTH = 4 and no irq -> job_ready falls after 5 accepts (1 issued + 4 queued), source holds the 6th descriptor stable, no loss after irqs resume.
- Simultaneous irqs: MVUs 0, 4, 7 busy, all irqs in one cycle -> jobs_done += 3, busy = 0. An irq[5] with MVU 5 idle -> err_spurious = 8'h20, sticky until reset.
- Watchdog with TIMEOUT_CYCLES = 16: start MVU 2 with no irq -> busy[2] drops exactly 16 cycles after rising, err_timeout = 8'h04, jobs_done unchanged. Repeating with irq on cycle 16 -> completion counted, no timeout.
